// File: rtl/mult_pkg.sv
// Shared defaults and FSM encoding for the multiplier dispatch block.
package mult_pkg;

  localparam int unsigned WIDTH_DEF      = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 32;

  // Dispatch FSM states; START drives the one-cycle multiplier kick.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ARM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/mult_dispatch_fifo.sv
// Synchronous operand FIFO with occupancy count; read data is the head entry.
module mult_dispatch_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mult_dispatch.sv
// Feeds buffered operand pairs to a start/done multiplier and returns results
// on a valid/ready stream, aborting hung operations with a watchdog.
module mult_dispatch
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*WIDTH-1:0]            out_product,
  output logic                          out_timeout,
  output logic                          mul_start,
  output logic [WIDTH-1:0]              mul_multiplicand,
  output logic [WIDTH-1:0]              mul_multiplier,
  input  logic [2*WIDTH-1:0]            mul_product,
  input  logic                          mul_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned WW = $clog2(TIMEOUT) + 1;

  state_t          state;
  state_t          state_next;
  logic            pop;
  logic            done_hit;
  logic            timeout_hit;
  logic            fifo_full;
  logic [DW-1:0]   fifo_rdata;
  logic [WW-1:0]   wd_count;

  // Nothing is accepted while reset is held, even though the FIFO is empty.
  assign in_ready = reset && !fifo_full;

  mult_dispatch_fifo #(
    .DATA_W (DW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and control strobes; ARM deliberately ignores a stale done.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((fifo_count != '0) && !out_valid) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: state_next = ST_ARM;
      ST_ARM:   state_next = ST_WAIT;
      ST_WAIT: begin
        if (mul_done) begin
          done_hit   = 1'b1;
          state_next = ST_RESULT;
        end else if (wd_count == WW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_RESULT;
        end
      end
      ST_RESULT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Watchdog: cleared while the start pulse is out, counts ARM and WAIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_count <= '0;
    end else if (state == ST_START) begin
      wd_count <= '0;
    end else if ((state == ST_ARM) || (state == ST_WAIT)) begin
      wd_count <= wd_count + WW'(1);
    end
  end

  // Multiplier interface registers; operands only change on a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      busy             <= 1'b0;
    end else begin
      mul_start <= (state_next == ST_START);
      busy      <= (state_next != ST_IDLE);
      if (pop) begin
        mul_multiplicand <= fifo_rdata[DW-1:WIDTH];
        mul_multiplier   <= fifo_rdata[WIDTH-1:0];
      end
    end
  end

  // Result register held until the consumer handshakes; done beats timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (done_hit) begin
        out_product <= mul_product;
        out_timeout <= 1'b0;
      end else if (timeout_hit) begin
        out_product <= '0;
        out_timeout <= 1'b1;
      end
      if (done_hit || timeout_hit) out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch with a behavioural multiplier model.
module tb_mult_dispatch;

  localparam int unsigned W = 4;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_product;
  logic           out_timeout;
  logic           mul_start;
  logic [W-1:0]   mul_multiplicand;
  logic [W-1:0]   mul_multiplier;
  logic [2*W-1:0] mul_product;
  logic           mul_done;
  logic           busy;
  logic [2:0]     fifo_count;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int mode = 0;            // 0 real (3-cycle), 1 done stuck 0, 2 done stuck 1
  logic [2*W:0] res_q[$];  // {timeout, product}

  logic [2:0]   m_cnt;
  logic [W-1:0] m_a, m_b;

  mult_dispatch #(.WIDTH(W), .FIFO_DEPTH(4), .TIMEOUT(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .out_timeout      (out_timeout),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_done         (mul_done),
    .busy             (busy),
    .fifo_count       (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: done stays high after completion until the next start.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_done    <= 1'b0;
      mul_product <= '0;
      m_cnt       <= '0;
      m_a         <= '0;
      m_b         <= '0;
    end else begin
      case (mode)
        0: begin
          if (mul_start) begin
            mul_done <= 1'b0;
            m_cnt    <= 3'd3;
            m_a      <= mul_multiplicand;
            m_b      <= mul_multiplier;
          end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 3'd1;
            if (m_cnt == 3'd1) begin
              mul_done    <= 1'b1;
              mul_product <= (2*W)'(m_a) * (2*W)'(m_b);
            end
          end
        end
        1: mul_done <= 1'b0;
        default: begin
          mul_done <= 1'b1;
          if (mul_start) mul_product <= (2*W)'(mul_multiplicand) * (2*W)'(mul_multiplier);
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset && mul_start) start_cnt <= start_cnt + 1;
    if (reset && out_valid && out_ready) res_q.push_back({out_timeout, out_product});
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [2*W-1:0] prod, input logic to);
    logic [2*W:0] r;
    chk({tag, "_avail"}, 32'(res_q.size() != 0), 32'd1);
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      chk({tag, "_prod"}, 32'(r[2*W-1:0]), 32'(prod));
      chk({tag, "_to"}, 32'(r[2*W]), 32'(to));
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !out_valid; i++) tick();
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 400 && res_q.size() < n; i++) tick();
  endtask

  initial begin
    int s0;
    int n;
    logic [2*W-1:0] held;
    reset = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #3;
    // Reset values.
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_product", 32'(out_product), 32'd0);
    chk("rst_out_timeout", 32'(out_timeout), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mcand", 32'(mul_multiplicand), 32'd0);
    chk("rst_mplier", 32'(mul_multiplier), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Single pair 4*3.
    s0 = start_cnt;
    push(4'd4, 4'd3);
    wait_valid();
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_prod", 32'(out_product), 32'd12);
    chk("p1_to", 32'(out_timeout), 32'd0);
    chk("p1_starts", 32'(start_cnt - s0), 32'd1);
    tick();
    chk("p1_valid_clear", 32'(out_valid), 32'd0);
    res_q.delete();

    // Back-to-back pairs.
    s0 = start_cnt;
    push(4'd7, 4'd9);
    push(4'd15, 4'd15);
    push(4'd0, 4'd11);
    wait_results(3);
    chk_res("b2b0", 8'd63, 1'b0);
    chk_res("b2b1", 8'd225, 1'b0);
    chk_res("b2b2", 8'd0, 1'b0);
    chk("b2b_starts", 32'(start_cnt - s0), 32'd3);

    // Backpressure: fill the FIFO, then drain.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(W'(k), W'(k));
    chk("bp_count_full", 32'(fifo_count), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_a = 4'd6;
    in_b = 4'd6;
    repeat (3) tick();
    chk("bp_no_overwrite", 32'(fifo_count), 32'd4);
    wait_valid();
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    held = out_product;
    chk("bp_first_prod", 32'(held), 32'd1);
    repeat (4) tick();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_prod", 32'(out_product), 32'd1);
    chk("bp_hold_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 400 && (res_q.size() < 6 || in_valid); i++) begin
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    chk_res("bp0", 8'd1, 1'b0);
    chk_res("bp1", 8'd4, 1'b0);
    chk_res("bp2", 8'd9, 1'b0);
    chk_res("bp3", 8'd16, 1'b0);
    chk_res("bp4", 8'd25, 1'b0);
    chk_res("bp5", 8'd36, 1'b0);

    // Hung multiplier: watchdog abort, then normal operation.
    mode = 1;
    push(4'd2, 4'd2);
    for (int i = 0; i < 20 && !mul_start; i++) tick();
    chk("to_start_seen", 32'(mul_start), 32'd1);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'd33);
    chk("to_valid", 32'(out_valid), 32'd1);
    chk("to_flag", 32'(out_timeout), 32'd1);
    chk("to_prod", 32'(out_product), 32'd0);
    tick();
    res_q.delete();
    mode = 0;
    push(4'd3, 4'd5);
    wait_results(1);
    chk_res("after_to", 8'd15, 1'b0);

    // Done stuck high: ARM skips it, capture on first WAIT cycle.
    mode = 2;
    push(4'd6, 4'd7);
    for (int i = 0; i < 20 && !mul_start; i++) tick();
    chk("s1_start_seen", 32'(mul_start), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("s1_latency", 32'(n), 32'd3);
    chk("s1_prod", 32'(out_product), 32'd42);
    chk("s1_to", 32'(out_timeout), 32'd0);
    tick();
    res_q.delete();

    // Reset in WAIT with two pairs queued.
    mode = 1;
    push(4'd1, 4'd2);
    push(4'd2, 4'd3);
    push(4'd3, 4'd4);
    repeat (5) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_mcand", 32'(mul_multiplicand), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_mcand", 32'(mul_multiplicand), 32'd0);
    chk("arst_mplier", 32'(mul_multiplier), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    mode = 0;
    s0 = start_cnt;
    repeat (10) tick();
    chk("post_rst_starts", 32'(start_cnt - s0), 32'd0);
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    res_q.delete();
    push(4'd2, 4'd5);
    wait_results(1);
    chk_res("post_rst", 8'd10, 1'b0);
    chk("post_rst_one_start", 32'(start_cnt - s0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
